// File: rtl/eeg_pea_pkg.sv
// Shared types for the PE-array output path: collector FSM states and the
// [col][row] -> flat PE index mapping used by every per-PE port.
package eeg_pea_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE_S} pea_st_e;

    function automatic int flat_idx(int col, int row, int pe_row);
        return col * pe_row + row;
    endfunction

endpackage

// File: rtl/eeg_pea_out_col_if.sv
// PE output streams into the collector and the single-port ORAM write bus out of it.
interface eeg_pea_out_col_if #(
    parameter int PE_ROW      = 4,
    parameter int PE_COL      = 4,
    parameter int DATA_OUT_DW = 8,
    parameter int OMUX_ADD_AW = 8,
    parameter int ORAM_ADD_AW = 10
);
    logic [PE_COL-1:0][PE_ROW-1:0]                  OUT_VLD;
    logic [PE_COL-1:0][PE_ROW-1:0]                  OUT_LST;
    logic [PE_COL-1:0][PE_ROW-1:0]                  OUT_RDY;
    logic [PE_COL-1:0][PE_ROW-1:0][DATA_OUT_DW-1:0] OUT_DAT;
    logic [PE_COL-1:0][PE_ROW-1:0][OMUX_ADD_AW-1:0] OUT_ADD;
    logic                                           ORAM_WEN;
    logic                                           ORAM_RDY;
    logic [ORAM_ADD_AW-1:0]                         ORAM_ADD;
    logic [DATA_OUT_DW-1:0]                         ORAM_DAT;

    // master = collector side
    modport master (
        input  OUT_VLD, OUT_LST, OUT_DAT, OUT_ADD, ORAM_RDY,
        output OUT_RDY, ORAM_WEN, ORAM_ADD, ORAM_DAT
    );
    modport slave (
        output OUT_VLD, OUT_LST, OUT_DAT, OUT_ADD, ORAM_RDY,
        input  OUT_RDY, ORAM_WEN, ORAM_ADD, ORAM_DAT
    );
endinterface

// File: rtl/eeg_rr_arb.sv
// N-way round-robin arbiter: first requester at or above ptr, wrapping.
module eeg_rr_arb #(
    parameter int N  = 16,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] j;

    // Scan offsets high to low so the smallest offset from ptr wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = IW'((int'(ptr) + i) % N);
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = j;
                any    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/eeg_pea_out_col.sv
// PE-array output collector: round-robin merges the per-PE streams into ORAM
// writes at base + k*stride + local address, and pulses DONE once all PEs finish.
module eeg_pea_out_col
    import eeg_pea_pkg::*;
#(
    parameter int PE_ROW      = 4,
    parameter int PE_COL      = 4,
    parameter int DATA_OUT_DW = 8,
    parameter int OMUX_ADD_AW = 8,
    parameter int ORAM_ADD_AW = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   START,
    input  logic [ORAM_ADD_AW-1:0] CFG_OUT_BASE,
    input  logic [ORAM_ADD_AW-1:0] CFG_OUT_STRIDE,
    output logic                   IS_IDLE,
    output logic                   DONE,
    output logic [ORAM_ADD_AW:0]   OUT_CNT,
    eeg_pea_out_col_if.master      bus
);
    localparam int PE_NUM = PE_ROW * PE_COL;
    localparam int PE_IW  = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;

    pea_st_e                              state;
    logic [ORAM_ADD_AW-1:0]               base_q, stride_q;
    logic [PE_NUM-1:0]                    lst_seen, lst_nxt;
    logic [PE_IW-1:0]                     rr_ptr, gidx;
    logic                                 wr_vld;
    logic [ORAM_ADD_AW-1:0]               wr_add, wadd_n;
    logic [DATA_OUT_DW-1:0]               wr_dat;
    logic [PE_NUM-1:0]                    vld_f, lst_f, gnt;
    logic [PE_NUM-1:0][DATA_OUT_DW-1:0]   dat_f;
    logic [PE_NUM-1:0][OMUX_ADD_AW-1:0]   add_f;
    logic                                 gany, can_load, acc;

    for (genvar c = 0; c < PE_COL; c++) begin : g_col
        for (genvar r = 0; r < PE_ROW; r++) begin : g_row
            localparam int K = flat_idx(c, r, PE_ROW);
            assign vld_f[K] = bus.OUT_VLD[c][r];
            assign lst_f[K] = bus.OUT_LST[c][r];
            assign dat_f[K] = bus.OUT_DAT[c][r];
            assign add_f[K] = bus.OUT_ADD[c][r];
        end
    end

    eeg_rr_arb #(.N(PE_NUM), .IW(PE_IW)) u_arb (
        .req (vld_f),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (gany)
    );

    // A word can enter the write stage only if that stage is empty or emptying now.
    assign can_load = ~wr_vld | bus.ORAM_RDY;
    assign acc      = (state == RUN) & gany & can_load;
    assign lst_nxt  = lst_seen | ((acc & lst_f[gidx]) ? gnt : '0);
    assign wadd_n   = base_q + ORAM_ADD_AW'(gidx) * stride_q + ORAM_ADD_AW'(add_f[gidx]);

    // Flat grant vector shares the [col][row] packing of the port.
    assign bus.OUT_RDY  = acc ? gnt : '0;
    assign bus.ORAM_WEN = wr_vld;
    assign bus.ORAM_ADD = wr_add;
    assign bus.ORAM_DAT = wr_dat;
    assign IS_IDLE      = (state == IDLE);
    assign DONE         = (state == DONE_S);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            base_q   <= '0;
            stride_q <= '0;
            lst_seen <= '0;
            rr_ptr   <= '0;
            wr_vld   <= 1'b0;
            wr_add   <= '0;
            wr_dat   <= '0;
            OUT_CNT  <= '0;
        end else begin
            case (state)
                IDLE: if (START) begin
                    state    <= RUN;
                    base_q   <= CFG_OUT_BASE;
                    stride_q <= CFG_OUT_STRIDE;
                    lst_seen <= '0;
                end
                RUN: begin
                    lst_seen <= lst_nxt;
                    if (&lst_nxt) state <= DRAIN;
                end
                DRAIN:   if (can_load) state <= DONE_S;
                default: state <= IDLE;
            endcase

            if (acc) begin
                wr_vld <= 1'b1;
                wr_add <= wadd_n;
                wr_dat <= dat_f[gidx];
                rr_ptr <= (gidx == PE_IW'(PE_NUM - 1)) ? '0 : gidx + 1'b1;
            end else if (bus.ORAM_RDY) begin
                wr_vld <= 1'b0;
            end

            if (state == IDLE && START)
                OUT_CNT <= '0;
            else if (wr_vld && bus.ORAM_RDY && !(&OUT_CNT))
                OUT_CNT <= OUT_CNT + 1'b1;
        end
    end
endmodule

// File: tb/tb_eeg_pea_out_col.sv
// Randomised bench for eeg_pea_out_col against a cycle-level behavioural model.
module tb_eeg_pea_out_col;
    localparam int PR = 4, PC = 4, DW = 8, LAW = 8, AW = 10, N = PR * PC;
    localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_DONE = 3;

    typedef struct packed {
        logic [7:0] add;
        logic [7:0] dat;
        logic       lst;
    } word_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_base = '0, cfg_stride = '0;
    logic          is_idle, done;
    logic [AW:0]   out_cnt;

    eeg_pea_out_col_if #(.PE_ROW(PR), .PE_COL(PC), .DATA_OUT_DW(DW),
                         .OMUX_ADD_AW(LAW), .ORAM_ADD_AW(AW)) bus ();

    eeg_pea_out_col #(.PE_ROW(PR), .PE_COL(PC), .DATA_OUT_DW(DW),
                      .OMUX_ADD_AW(LAW), .ORAM_ADD_AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .START          (start),
        .CFG_OUT_BASE   (cfg_base),
        .CFG_OUT_STRIDE (cfg_stride),
        .IS_IDLE        (is_idle),
        .DONE           (done),
        .OUT_CNT        (out_cnt),
        .bus            (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // PE word sources
    word_t       peq [N][8];
    int          ph [N], pn [N];
    logic [N-1:0] en;
    logic        start_r = 1'b0, oram_rdy_r = 1'b1;

    // reference model state
    int          m_st = S_IDLE, m_ptr = 0, m_base = 0, m_stride = 0, m_cnt = 0, m_add = 0, m_dat = 0;
    logic        m_pend = 1'b0;
    logic [N-1:0] m_lst = '0;

    // observations and per-pass statistics
    logic [N-1:0] obs_rdy;
    logic         obs_wen, obs_done;
    logic [AW-1:0] obs_add, last_wadd, cap_add;
    logic [DW-1:0] obs_dat, last_wdat, cap_dat;
    int cyc = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0, last_acc_cyc = 0;
    int first_wcyc = 0, last_wcyc = 0;
    int acc_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_q();
        for (int k = 0; k < N; k++) begin
            ph[k] = 0;
            pn[k] = 0;
        end
    endtask

    task automatic load_full(input int nw);
        for (int k = 0; k < N; k++) begin
            ph[k] = 0;
            pn[k] = nw;
            for (int i = 0; i < nw; i++) begin
                peq[k][i].add = 8'($urandom);
                peq[k][i].dat = 8'($urandom);
                peq[k][i].lst = (i == nw - 1);
            end
        end
    endtask

    // One clock: drive at negedge, check at negedge+1, advance the model over the next posedge.
    task automatic step();
        logic [N-1:0] vf;
        word_t w;
        int g;
        logic can, drain_ok;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            vf[k] = en[k] && (ph[k] < pn[k]);
            if (vf[k]) w = peq[k][ph[k]];
            else begin
                w.add = 8'($urandom);
                w.dat = 8'($urandom);
                w.lst = 1'($urandom);
            end
            bus.OUT_VLD[k/PR][k%PR] = vf[k];
            bus.OUT_LST[k/PR][k%PR] = w.lst;
            bus.OUT_DAT[k/PR][k%PR] = w.dat;
            bus.OUT_ADD[k/PR][k%PR] = w.add;
        end
        bus.ORAM_RDY = oram_rdy_r;
        start = start_r;
        #1;
        obs_rdy  = bus.OUT_RDY;
        obs_wen  = bus.ORAM_WEN;
        obs_add  = bus.ORAM_ADD;
        obs_dat  = bus.ORAM_DAT;
        obs_done = done;

        can = !m_pend || oram_rdy_r;
        g = -1;
        if (m_st == S_RUN && can)
            for (int i = 0; i < N; i++)
                if (g < 0 && vf[(m_ptr + i) % N]) g = (m_ptr + i) % N;

        chk("rdy", 32'(obs_rdy), (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("wen", 32'(obs_wen), 32'(m_pend));
        if (m_pend) begin
            chk("wadd", 32'(obs_add), 32'(m_add));
            chk("wdat", 32'(obs_dat), 32'(m_dat));
        end
        chk("done", 32'(obs_done), 32'(m_st == S_DONE));
        chk("idle", 32'(is_idle), 32'(m_st == S_IDLE));
        chk("cnt", 32'(out_cnt), 32'(m_cnt));

        if (obs_wen && oram_rdy_r) begin
            if (wr_cnt == 0) first_wcyc = cyc;
            wr_cnt++;
            last_wcyc = cyc;
            last_wadd = obs_add;
            last_wdat = obs_dat;
        end
        if (obs_done) begin
            done_cnt++;
            done_cyc = cyc;
        end

        drain_ok = can;
        if (m_pend && oram_rdy_r) begin
            m_pend = 1'b0;
            if (m_cnt < 2047) m_cnt++;
        end
        if (g >= 0) begin
            w = peq[g][ph[g]];
            ph[g]++;
            m_pend = 1'b1;
            m_add  = (m_base + g * m_stride + int'(w.add)) % 1024;
            m_dat  = int'(w.dat);
            m_ptr  = (g + 1) % N;
            if (w.lst) m_lst[g] = 1'b1;
            acc_log.push_back(g);
            last_acc_cyc = cyc;
        end
        case (m_st)
            S_IDLE: if (start_r) begin
                m_st = S_RUN;
                m_base = int'(cfg_base);
                m_stride = int'(cfg_stride);
                m_lst = '0;
                m_cnt = 0;
            end
            S_RUN:   if (&m_lst) m_st = S_DRAIN;
            S_DRAIN: if (drain_ok) m_st = S_DONE;
            default: m_st = S_IDLE;
        endcase
        start_r = 1'b0;
        cyc++;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        start = 1'b0;
        #1;
        chk("rst_wen", 32'(bus.ORAM_WEN), 32'd0);
        chk("rst_add", 32'(bus.ORAM_ADD), 32'd0);
        chk("rst_dat", 32'(bus.ORAM_DAT), 32'd0);
        chk("rst_rdy", 32'(bus.OUT_RDY), 32'd0);
        chk("rst_idle", 32'(is_idle), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cnt", 32'(out_cnt), 32'd0);
        m_st = S_IDLE; m_ptr = 0; m_pend = 1'b0; m_cnt = 0; m_lst = '0;
        clear_q();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // rmode: 0 ORAM always ready, 1 five-cycle stall at n=20, 2 random
    // emode: 0 all PEs offer, 2 only PE7 for 6 cycles then random offers
    task automatic run_pass(input int bound, input int rmode, input int emode);
        int n = 0;
        logic fin = 1'b0;
        wr_cnt = 0;
        done_cnt = 0;
        acc_log.delete();
        start_r = 1'b1;
        while (n < bound && !fin) begin
            case (rmode)
                0:       oram_rdy_r = 1'b1;
                1:       oram_rdy_r = !(n >= 20 && n < 25);
                default: oram_rdy_r = (n < 6) ? 1'b1 : ($urandom_range(3) != 0);
            endcase
            if (emode == 2) en = (n < 6) ? N'(1 << 7) : N'($urandom);
            else            en = '1;
            if (rmode == 2 && n == 3) begin
                start_r  = 1'b1;
                cfg_base = AW'($urandom);
            end
            step();
            if (rmode == 1 && n == 20) begin
                cap_add = obs_add;
                cap_dat = obs_dat;
            end
            if (rmode == 1 && n > 20 && n < 25) begin
                chk("bp_wen", 32'(obs_wen), 32'd1);
                chk("bp_add", 32'(obs_add), 32'(cap_add));
                chk("bp_dat", 32'(obs_dat), 32'(cap_dat));
                chk("bp_rdy", 32'(obs_rdy), 32'd0);
            end
            if (emode == 2 && n == 5) chk("post_lst_acc", ph[7], 2);
            if (obs_done) fin = 1'b1;
            n++;
        end
        chk("pass_end", 32'(fin), 32'd1);
    endtask

    initial begin
        int total, p0;
        bus.OUT_VLD = '0; bus.OUT_LST = '0; bus.OUT_DAT = '0; bus.OUT_ADD = '0;
        bus.ORAM_RDY = 1'b1;
        en = '0;
        clear_q();
        do_reset();

        // OUT_VLD while IDLE must see no ready
        load_full(1);
        en = '1;
        repeat (3) step();
        clear_q();

        // single PE, DONE must never fire
        cfg_base = 10'h100; cfg_stride = 10'h020;
        pn[5] = 1;
        peq[5][0] = '{add: 8'h03, dat: 8'hA5, lst: 1'b1};
        wr_cnt = 0; done_cnt = 0;
        start_r = 1'b1;
        repeat (12) step();
        chk("single_wcnt", wr_cnt, 1);
        chk("single_add", 32'(last_wadd), 32'h1A3);
        chk("single_dat", 32'(last_wdat), 32'hA5);
        chk("single_lat", last_wcyc, last_acc_cyc + 1);
        chk("single_nodone", done_cnt, 0);
        do_reset();

        // address wraps mod 2^ORAM_ADD_AW
        cfg_base = 10'h3F0; cfg_stride = 10'h010;
        pn[2] = 1;
        peq[2][0] = '{add: 8'h30, dat: 8'h5C, lst: 1'b0};
        wr_cnt = 0;
        start_r = 1'b1;
        repeat (8) step();
        chk("wrap_add", 32'(last_wadd), 32'h040);
        chk("wrap_wcnt", wr_cnt, 1);
        do_reset();

        // full pass at full throughput
        cfg_base = AW'($urandom); cfg_stride = AW'($urandom);
        load_full(4);
        p0 = m_ptr;
        run_pass(200, 0, 0);
        chk("full_wcnt", wr_cnt, 64);
        chk("full_cnt", 32'(out_cnt), 32'd64);
        chk("full_nogap", last_wcyc - first_wcyc, 63);
        chk("full_done_lat", done_cyc - last_acc_cyc, 2);
        chk("full_done_once", done_cnt, 1);
        for (int i = 0; i < acc_log.size(); i++) chk("full_order", acc_log[i], (p0 + i) % N);

        // back-pressure mid-stream
        load_full(4);
        run_pass(200, 1, 0);
        chk("bp_wcnt", wr_cnt, 64);
        chk("bp_cnt", 32'(out_cnt), 32'd64);

        // random passes: gated offers, random ORAM ready, START while RUN, post-LST word
        for (int it = 0; it < 3; it++) begin
            cfg_base = AW'($urandom); cfg_stride = AW'($urandom);
            total = 0;
            for (int k = 0; k < N; k++) begin
                ph[k] = 0;
                pn[k] = (k == 7) ? 2 : int'($urandom_range(1, 5));
                for (int i = 0; i < pn[k]; i++) begin
                    peq[k][i].add = 8'($urandom);
                    peq[k][i].dat = 8'($urandom);
                    peq[k][i].lst = (k == 7) ? (i == 0) : (i == pn[k] - 1);
                end
                total += pn[k];
            end
            run_pass(600, 2, 2);
            chk("rnd_wcnt", wr_cnt, total);
            chk("rnd_cnt", 32'(out_cnt), 32'(total));
        end

        // reset with a write pending, then a clean pass
        load_full(4);
        en = '1;
        oram_rdy_r = 1'b1;
        start_r = 1'b1;
        repeat (6) step();
        oram_rdy_r = 1'b0;
        repeat (2) step();
        chk("pend_before_rst", 32'(obs_wen), 32'd1);
        do_reset();
        load_full(4);
        run_pass(200, 0, 0);
        chk("post_rst_wcnt", wr_cnt, 64);
        chk("post_rst_cnt", 32'(out_cnt), 32'd64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/eeg_pea_out_col.md
# eeg_pea_out_col

Output collector for the PE array: the receiving end of the per-PE output streams (VLD/LST/RDY/DAT/ADD) that the PE engine emits, one stream per PE in [PE_COL][PE_ROW] packing. It round-robin arbitrates the PE_ROW*PE_COL streams and serialises accepted words into single-port ORAM writes at base + pe_idx*stride + local address. It tracks each PE's last-word flag and pulses DONE once every PE has delivered its last word and the write stage has drained.

## Interface
- PE_ROW, 4, PE rows
- PE_COL, 4, PE columns
- DATA_OUT_DW, 8, output word width
- OMUX_ADD_AW, 8, per-PE local output address width
- ORAM_ADD_AW, 10, ORAM address width
- PE_NUM (localparam), PE_ROW*PE_COL; PE_IW = $clog2(PE_NUM)

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- START  in  1  begin a collection pass; ignored unless IDLE
- CFG_OUT_BASE  in  ORAM_ADD_AW  ORAM base address, sampled on START
- CFG_OUT_STRIDE  in  ORAM_ADD_AW  per-PE address stride, sampled on START
- IS_IDLE  out  1  high in IDLE
- DONE  out  1  one-cycle pulse at end of pass
- OUT_CNT  out  ORAM_ADD_AW+1  words written this pass, saturating
- OUT_VLD  in  [PE_COL][PE_ROW]  per-PE word valid
- OUT_LST  in  [PE_COL][PE_ROW]  per-PE last word
- OUT_RDY  out  [PE_COL][PE_ROW]  per-PE ready
- OUT_DAT  in  [PE_COL][PE_ROW][DATA_OUT_DW]  per-PE data
- OUT_ADD  in  [PE_COL][PE_ROW][OMUX_ADD_AW]  per-PE local address
- ORAM_WEN  out  1  write request
- ORAM_RDY  in  1  ORAM accepts write this cycle
- ORAM_ADD  out  ORAM_ADD_AW  write address
- ORAM_DAT  out  DATA_OUT_DW  write data

## Operation
- Flat index k = col*PE_ROW + row, the same order as the port packing.
- FSM: IDLE -START-> RUN; RUN -(all lst_seen set)-> DRAIN; DRAIN -(write stage empty)-> DONE_S; DONE_S -> IDLE unconditionally. DONE=1 only in DONE_S.
- On START: latch base and stride, clear lst_seen[PE_NUM], clear OUT_CNT. Do not reset the RR pointer.
- Arbitration in RUN: grant the first k with OUT_VLD[k]=1, searching from rr_ptr upward with wrap. OUT_RDY[k] = RUN & grant==k & (~wr_vld | ORAM_RDY). At most one OUT_RDY is high.
- Handshake on OUT_VLD[k]&OUT_RDY[k]:
  - load write stage: wr_vld=1, wr_add = base + k*stride + OUT_ADD[k], sum truncated mod 2^ORAM_ADD_AW; wr_dat = OUT_DAT[k].
  - set rr_ptr = k+1 (wrap to 0 after PE_NUM-1).
  - if OUT_LST[k]=1, set lst_seen[k].
- Write stage: ORAM_WEN=wr_vld. It clears on ORAM_RDY unless reloaded the same cycle. OUT_CNT increments per ORAM_WEN&ORAM_RDY, saturating at all-ones.
- A word arriving after its PE's lst_seen is set (still RUN) is accepted and written normally; the flag stays set.
- OUT_RDY is all-zero in IDLE, DRAIN and DONE_S. OUT_VLD is ignored there.
- START outside IDLE is ignored.

## Timing
- Reset values: OUT_RDY=0, ORAM_WEN=0, ORAM_ADD=0, ORAM_DAT=0, DONE=0, IS_IDLE=1, OUT_CNT=0, rr_ptr=0, lst_seen=0, state IDLE.
- START at cycle t gives RUN at t+1; the first OUT_RDY can be high at t+1.
- Accept at cycle t gives ORAM_WEN=1 at t+1 with address and data stable.
- While ORAM_RDY=0: ORAM_WEN, ORAM_ADD and ORAM_DAT hold, and all OUT_RDY are low.
- Throughput is one word per cycle when ORAM_RDY is held high. With all PEs valid, each PE is granted once every PE_NUM cycles.
- If the final lst_seen bit sets at cycle t: DRAIN at t+1; DONE pulses at t+2 when ORAM_RDY=1 at t+1, otherwise one cycle after the final write completes.
- Asynchronous rst mid-pass: everything returns to reset values immediately. A pending write is dropped.

## Structure
- Shared package eeg_pea_pkg: FSM state enum (IDLE, RUN, DRAIN, DONE_S) and the index-flatten helper.
- One sub-module: eeg_rr_arb, a parameterised N-way round-robin arbiter (req, ptr -> one-hot grant plus index). Everything else is inline.

## Test plan
- Single PE: START with base=0x100, stride=0x20; only PE k=5 sends add=3, dat=0xA5, lst=1, others send nothing. Required: ORAM write 0x1A3/0xA5 one cycle after accept. Since the other PEs never assert LST, DONE must not fire; then reset.
- Full pass: all 16 PEs send 4 words each, last with lst=1, ORAM_RDY=1. Required: 64 writes in strict k-order rotation, no gaps; OUT_CNT=64; DONE pulses 2 cycles after the final accept.
- Back-pressure: ORAM_RDY=0 for 5 cycles mid-stream. Required: WEN/ADD/DAT held constant, all OUT_RDY=0, no word lost or duplicated.
- Wrap: base=0x3F0, stride=0x10, k=2, add=0x30. Required: ORAM_ADD=(0x3F0+0x20+0x30) mod 1024 = 0x040.
- Protocol edges: START while RUN is ignored; OUT_VLD in IDLE gets no RDY; a post-LST word from the same PE is still written.
- Reset mid-pass with a write pending: ORAM_WEN drops immediately, IS_IDLE=1, and a new START runs a clean pass with OUT_CNT starting at 0.
